// File: rtl/ram_sdp_param.sv
//------------------------------------------------------------------------------
// ram_sdp_param
//
// Simple-dual-port RAM with one write port and one read port on a single
// clock. It succeeds the 4-bit x 8 scratch store. Features:
//   - generic word width and depth
//   - per-lane write enables
//   - 1- or 2-cycle registered read with a valid strobe
//   - selectable same-address read/write collision policy
//   - hardware clear of every word to INIT_VALUE after each reset
//
// Ports
//   clk        in   1           clock, rising edge
//   rst        in   1           synchronous active-high reset
//   wr_en      in   1           write request
//   wr_addr    in   ADDR_WIDTH  write address
//   wr_be      in   NLANES      lane enables, bit i -> data[i*LANE_WIDTH +: LANE_WIDTH]
//   wr_data    in   DATA_WIDTH  write data
//   rd_en      in   1           read request
//   rd_addr    in   ADDR_WIDTH  read address
//   rd_data    out  DATA_WIDTH  read data, holds until the next completing read
//   rd_valid   out  1           one-cycle strobe, rd_data valid
//   init_busy  out  1           clear sequence running, requests ignored
//
// FSM
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_CLEAR  | writing INIT_VALUE to mem[r_clr_addr], one word per cycle
//   S_IDLE   | normal operation, reads and writes accepted
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module ram_sdp_param #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    LANE_WIDTH     = 4,
    parameter int                    ADDR_WIDTH     = 4,
    parameter int                    DEPTH          = 16,
    parameter int                    RD_LATENCY     = 1,
    parameter int                    COLLISION_MODE = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0,
    localparam int                   NLANES         = DATA_WIDTH / LANE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NLANES-1:0]     wr_be,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  init_busy
);

    //--------------------------------------------------------------------------
    // Elaboration-time parameter checks
    //--------------------------------------------------------------------------
    if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
        $error("ram_sdp_param: RD_LATENCY must be 1 or 2");
    end

    if ((DEPTH < 1) || (DEPTH > (2 ** ADDR_WIDTH))) begin : g_bad_depth
        $error("ram_sdp_param: DEPTH must be in 1 .. 2**ADDR_WIDTH");
    end

    if ((LANE_WIDTH < 1) || ((DATA_WIDTH % LANE_WIDTH) != 0)) begin : g_bad_lanes
        $error("ram_sdp_param: DATA_WIDTH must be a multiple of LANE_WIDTH");
    end

    if ((COLLISION_MODE != 0) && (COLLISION_MODE != 1)) begin : g_bad_collision
        $error("ram_sdp_param: COLLISION_MODE must be 0 or 1");
    end

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    // One extra bit so that DEPTH == 2**ADDR_WIDTH is representable in the
    // range compare.
    localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LP_ONE   = ADDR_WIDTH'(1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    //--------------------------------------------------------------------------
    // Declarations
    //--------------------------------------------------------------------------
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_clr_addr;
    logic [ADDR_WIDTH-1:0]   w_clr_addr_nxt;

    logic                    w_init_busy;
    logic                    w_clr_we;
    logic                    w_ops_en;

    logic                    w_wr_in_range;
    logic                    w_rd_in_range;
    logic                    w_wr_go;
    logic                    w_rd_go;
    logic                    w_same_addr;

    logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0]   w_rd_old;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    logic                    r_s1_valid;
    logic [DATA_WIDTH-1:0]   r_s1_data;

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            S_CLEAR: begin
                w_clr_addr_nxt = r_clr_addr + LP_ONE;
                if (r_clr_addr == LP_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt    = S_CLEAR;
                w_clr_addr_nxt = '0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: outputs
    // rst gates both the clear write and user requests, so memory is never
    // touched while reset is held.
    //--------------------------------------------------------------------------
    always_comb begin
        w_init_busy = 1'b0;
        w_clr_we    = 1'b0;
        w_ops_en    = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_init_busy = 1'b1;
                w_clr_we    = !rst;
            end
            S_IDLE: begin
                w_ops_en    = !rst;
            end
            default: begin
                w_init_busy = 1'b1;
            end
        endcase
    end

    assign init_busy = w_init_busy;

    //--------------------------------------------------------------------------
    // Request qualification
    //--------------------------------------------------------------------------
    assign w_wr_in_range = ({1'b0, wr_addr} < LP_DEPTH);
    assign w_rd_in_range = ({1'b0, rd_addr} < LP_DEPTH);
    assign w_wr_go       = w_ops_en && wr_en && w_wr_in_range;
    // Out-of-range reads are still accepted; they complete with data 0.
    assign w_rd_go       = w_ops_en && rd_en;
    assign w_same_addr   = (wr_addr == rd_addr);

    //--------------------------------------------------------------------------
    // Storage
    // Deliberately not reset: contents survive reset until the clear sequence
    // overwrites them.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_addr] <= INIT_VALUE;
        end else if (w_wr_go) begin
            for (int i = 0; i < NLANES; i++) begin
                if (wr_be[i]) begin
                    r_mem[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <=
                        wr_data[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Read word selection
    // The array read sees pre-write contents, which gives read-first
    // behaviour for free. Write-first merges the enabled lanes of the
    // concurrent write into the old word.
    //--------------------------------------------------------------------------
    always_comb begin
        w_rd_old  = '0;
        if (w_rd_in_range) begin
            w_rd_old = r_mem[rd_addr];
        end
        w_rd_word = w_rd_old;
        if ((COLLISION_MODE == 1) && w_wr_go && w_same_addr) begin
            for (int i = 0; i < NLANES; i++) begin
                if (wr_be[i]) begin
                    w_rd_word[i*LANE_WIDTH +: LANE_WIDTH] =
                        wr_data[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Read pipeline, first stage
    // Data is loaded only on an accepted read, so the output holds between
    // reads.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_rd_go;
            if (w_rd_go) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Optional second stage
    //--------------------------------------------------------------------------
    if (RD_LATENCY == 2) begin : g_lat2
        logic                  r_s2_valid;
        logic [DATA_WIDTH-1:0] r_s2_data;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s2_valid <= 1'b0;
                r_s2_data  <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign rd_valid = r_s2_valid;
        assign rd_data  = r_s2_data;
    end else begin : g_lat1
        assign rd_valid = r_s1_valid;
        assign rd_data  = r_s1_data;
    end

endmodule

// File: tb/tb_ram_sdp_param.sv
`timescale 1ns/1ps

module tb_ram_sdp_param;

    // Three instances share stimulus:
    //   0: latency 1, read-first, depth 16
    //   1: latency 2, write-first, depth 16
    //   2: latency 1, read-first, depth 12
    localparam logic [7:0] INIT = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [1:0]  wr_be = '0;
    logic [7:0]  wr_data = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;

    logic [2:0][7:0] rdd;
    logic [2:0]      rdv;
    logic [2:0]      busy;

    always #5 clk = ~clk;

    ram_sdp_param #(.INIT_VALUE(INIT)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rdd[0]), .rd_valid(rdv[0]), .init_busy(busy[0]));

    ram_sdp_param #(.RD_LATENCY(2), .COLLISION_MODE(1), .INIT_VALUE(INIT)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rdd[1]), .rd_valid(rdv[1]), .init_busy(busy[1]));

    ram_sdp_param #(.DEPTH(12), .INIT_VALUE(INIT)) u_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rdd[2]), .rd_valid(rdv[2]), .init_busy(busy[2]));

    typedef struct {
        logic [7:0] d;
        int         due;
    } exp_t;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    exp_t       sb [3][$];
    logic [7:0] mm [3][16];
    int         dep [3] = '{16, 16, 12};
    int         lat [3] = '{1, 2, 1};
    int         cmode [3] = '{0, 1, 0};
    exp_t       e_mon;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every valid strobe must match the oldest expected read,
    // both in data and in the cycle it was due.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            while (sb[i].size() > 0 && sb[i][0].due < cyc) begin
                total++; bad++;
                $display("FAIL sb_missing inst=%0d due=%0d now=%0d exp=%h", i, sb[i][0].due, cyc, sb[i][0].d);
                void'(sb[i].pop_front());
            end
            if (rdv[i] === 1'b1) begin
                total++;
                if (sb[i].size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected inst=%0d cyc=%0d got=%h", i, cyc, rdd[i]);
                end else begin
                    e_mon = sb[i].pop_front();
                    if (e_mon.due != cyc || rdd[i] !== e_mon.d) begin
                        bad++;
                        $display("FAIL sb_read inst=%0d got=%h@%0d exp=%h@%0d", i, rdd[i], cyc, e_mon.d, e_mon.due);
                    end
                end
            end
        end
    end

    task automatic op(input logic we, input logic [3:0] wa, input logic [1:0] be,
                      input logic [7:0] wd, input logic re, input logic [3:0] ra);
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        rd_en = re; rd_addr = ra;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] old_w;
            logic [7:0] new_w;
            exp_t       e;
            old_w = (int'(ra) < dep[i]) ? mm[i][ra] : 8'h00;
            new_w = old_w;
            if (we && wa == ra && int'(wa) < dep[i]) begin
                if (be[0]) new_w[3:0] = wd[3:0];
                if (be[1]) new_w[7:4] = wd[7:4];
            end
            if (re) begin
                e.d   = (cmode[i] == 1) ? new_w : old_w;
                e.due = cyc + lat[i];
                sb[i].push_back(e);
            end
            if (we && int'(wa) < dep[i]) begin
                if (be[0]) mm[i][wa][3:0] = wd[3:0];
                if (be[1]) mm[i][wa][7:4] = wd[7:4];
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) op(1'b0, 4'd0, 2'b00, 8'h00, 1'b0, 4'd0);
    endtask

    // Holds rst for n_hi edges, checks the reset state, then counts the
    // cycles init_busy stays high after release.
    task automatic do_reset(input int n_hi);
        int cnt [3];
        @(negedge clk);
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
        for (int i = 0; i < 3; i++)
            while (sb[i].size() > 0 && sb[i][$].due > cyc) void'(sb[i].pop_back());
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total += 3;
            if (rdv[i] !== 1'b0) begin bad++; $display("FAIL rst_valid inst=%0d got=%b exp=0", i, rdv[i]); end
            if (rdd[i] !== 8'h00) begin bad++; $display("FAIL rst_data inst=%0d got=%h exp=00", i, rdd[i]); end
            if (busy[i] !== 1'b1) begin bad++; $display("FAIL rst_busy inst=%0d got=%b exp=1", i, busy[i]); end
        end
        repeat (n_hi - 1) @(negedge clk);
        rst = 1'b0;
        cnt = '{0, 0, 0};
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < 3; i++) if (busy[i] === 1'b1) cnt[i]++;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (cnt[i] != dep[i]) begin
                bad++;
                $display("FAIL clear_cycles inst=%0d got=%0d exp=%0d", i, cnt[i], dep[i]);
            end
            for (int a = 0; a < 16; a++) mm[i][a] = INIT;
        end
    endtask

    task automatic test_reset;
        do_reset(3);
    endtask

    task automatic test_clear;
        do_reset(1);
        for (int a = 0; a < 16; a++) op(1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'(a));
        idle(4);
    endtask

    task automatic test_latency;
        op(1'b1, 4'd5, 2'b11, 8'h3C, 1'b0, 4'd0);
        op(1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd5);
        idle(3);
        op(1'b1, 4'd6, 2'b11, 8'h61, 1'b0, 4'd0);
        op(1'b1, 4'd7, 2'b11, 8'h72, 1'b0, 4'd0);
        op(1'b1, 4'd8, 2'b11, 8'h83, 1'b0, 4'd0);
        for (int a = 5; a < 9; a++) op(1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'(a));
        idle(4);
    endtask

    task automatic test_lanes;
        op(1'b1, 4'd2, 2'b11, 8'h00, 1'b0, 4'd0);
        op(1'b1, 4'd2, 2'b01, 8'hFF, 1'b0, 4'd0);
        op(1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd2);
        op(1'b1, 4'd2, 2'b00, 8'h77, 1'b0, 4'd0);
        op(1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd2);
        idle(4);
    endtask

    task automatic test_collision;
        op(1'b1, 4'd7, 2'b11, 8'h11, 1'b0, 4'd0);
        op(1'b1, 4'd7, 2'b10, 8'hEE, 1'b1, 4'd7);
        op(1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd7);
        // Different addresses in the same cycle must not interact.
        op(1'b1, 4'd3, 2'b11, 8'h9D, 1'b1, 4'd7);
        op(1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd3);
        idle(4);
    endtask

    task automatic test_out_of_range;
        op(1'b1, 4'd13, 2'b11, 8'h55, 1'b0, 4'd0);
        op(1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd13);
        op(1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd11);
        op(1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd15);
        idle(4);
    endtask

    task automatic test_reset_mid;
        op(1'b1, 4'd5, 2'b11, 8'h3C, 1'b0, 4'd0);
        op(1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd5);
        do_reset(1);
        op(1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd5);
        op(1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd0);
        idle(4);
    endtask

    initial begin
        test_reset;
        test_clear;
        test_latency;
        test_lanes;
        test_collision;
        test_out_of_range;
        test_reset_mid;
        idle(3);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (sb[i].size() != 0) begin
                bad++;
                $display("FAIL sb_drain inst=%0d left=%0d exp=0", i, sb[i].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
